cnn_layer_sequencer: RTL

// Parametrised top-level controller for an N-layer CNN pipeline (conv/pool/fc/...).

---
 rtl/cnn_layer_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cnn_layer_sequencer.sv
// Sequences NUM_LAYERS engines with start/done handshakes, per-layer bypass, batches, watchdog and abort.
// Outputs registered one cycle after the state that produces them; layer engines backpressure by withholding done.
module cnn_layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] bypass_mask,
    input  logic [CNT_W-1:0]      batch_len,
    input  logic                  relu_en,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    input  logic [DATA_W-1:0]     layer_result,
    output logic [DATA_W-1:0]     value,
    output logic                  value_valid,
    output logic [CNT_W-1:0]      img_index,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0] err_layer
);

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WD_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_FIN, S_ERR} state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [NUM_LAYERS-1:0]   mask_q, mask_nxt;
    logic [CNT_W-1:0]        blen_q, blen_nxt;
    logic                    relu_q, relu_nxt;
    logic [WD_W-1:0]         wd_cnt, wd_nxt;
    logic                    img_adv, img_adv_nxt;
    logic [NUM_LAYERS-1:0]   layer_start_nxt;
    logic [DATA_W-1:0]       value_nxt;
    logic                    value_valid_nxt;
    logic [CNT_W-1:0]        img_index_nxt;
    logic                    done_nxt;
    logic                    timeout_err_nxt;
    logic [IDX_W-1:0]        err_layer_nxt;

    logic [IDX_W-1:0]        first_in, first_q, next_q;
    logic                    has_next;
    logic                    last_img;

    // Lowest active layer of the incoming and latched masks, and next active layer above idx.
    always_comb begin
        first_in = '0;
        first_q  = '0;
        next_q   = '0;
        has_next = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (!bypass_mask[i]) first_in = IDX_W'(i);
            if (!mask_q[i]) first_q = IDX_W'(i);
            if (!mask_q[i] && (i > int'(idx))) begin
                next_q   = IDX_W'(i);
                has_next = 1'b1;
            end
        end
    end

    assign last_img = (blen_q == '0) || (img_index == blen_q - CNT_W'(1));

    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        mask_nxt        = mask_q;
        blen_nxt        = blen_q;
        relu_nxt        = relu_q;
        wd_nxt          = wd_cnt;
        img_adv_nxt     = img_adv;
        layer_start_nxt = '0;
        value_nxt       = value;
        value_valid_nxt = 1'b0;
        img_index_nxt   = img_index;
        done_nxt        = 1'b0;
        timeout_err_nxt = timeout_err;
        err_layer_nxt   = err_layer;

        case (state)
            S_IDLE: begin
                if (enable && !abort) begin
                    mask_nxt        = bypass_mask;
                    blen_nxt        = batch_len;
                    relu_nxt        = relu_en;
                    timeout_err_nxt = 1'b0;
                    img_index_nxt   = '0;
                    img_adv_nxt     = 1'b0;
                    idx_nxt         = first_in;
                    state_nxt       = (&bypass_mask) ? S_FIN : S_START;
                end
            end
            S_START: begin
                // The pulse is captured even when aborting: it was already issued.
                layer_start_nxt[idx] = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    wd_nxt = '0;
                    if (img_adv) begin
                        img_index_nxt = img_index + CNT_W'(1);
                        img_adv_nxt   = 1'b0;
                    end
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (layer_done[idx]) begin
                    if (has_next) begin
                        idx_nxt   = next_q;
                        state_nxt = S_START;
                    end else begin
                        value_nxt       = (relu_q && layer_result[DATA_W-1]) ? '0 : layer_result;
                        value_valid_nxt = 1'b1;
                        if (last_img) begin
                            state_nxt = S_FIN;
                        end else begin
                            img_adv_nxt = 1'b1;
                            idx_nxt     = first_q;
                            state_nxt   = S_START;
                        end
                    end
                end else if (WD_EN && (wd_cnt == WD_W'(TIMEOUT - 1))) begin
                    timeout_err_nxt = 1'b1;
                    err_layer_nxt   = idx;
                    state_nxt       = S_ERR;
                end else begin
                    wd_nxt = wd_cnt + WD_W'(1);
                end
            end
            S_FIN, S_ERR: begin
                if (!abort) done_nxt = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            mask_q      <= '0;
            blen_q      <= '0;
            relu_q      <= 1'b0;
            wd_cnt      <= '0;
            img_adv     <= 1'b0;
            layer_start <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            img_index   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            err_layer   <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            mask_q      <= mask_nxt;
            blen_q      <= blen_nxt;
            relu_q      <= relu_nxt;
            wd_cnt      <= wd_nxt;
            img_adv     <= img_adv_nxt;
            layer_start <= layer_start_nxt;
            value       <= value_nxt;
            value_valid <= value_valid_nxt;
            img_index   <= img_index_nxt;
            busy        <= (state_nxt != S_IDLE);
            done        <= done_nxt;
            timeout_err <= timeout_err_nxt;
            err_layer   <= err_layer_nxt;
        end
    end

endmodule
